cfu_requant: RTL and testbench
==============================

CFU_REQUANT -- requirements
Module: cfu_requant

Interface
REQ-001 Parameter ACT_MIN, default -128, lower clamp bound of the int8 output.
REQ-002 Parameter ACT_MAX, default 127, upper clamp bound of the int8 output.
REQ-003 Design has one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 cfg_valid  in  1  config write request.
REQ-007 cfg_ready  out  1  config write accepted when high with cfg_valid.
REQ-008 cfg_addr  in  2  register select: 0 bias, 1 mult, 2 shift, 3 out_zp.
REQ-009 cfg_data  in  32  write data; shift uses [4:0], out_zp uses [7:0].
REQ-010 acc_valid  in  1  accumulator word offered, i.e. the MAC_READ result of the upstream Cfu.
REQ-011 acc_ready  out  1  accumulator accepted when high with acc_valid.
REQ-012 acc_data  in  32  signed accumulator.
REQ-013 flush  in  1  single-cycle pulse requesting emission of a partial word.
REQ-014 out_valid  out  1  packed output word valid.
REQ-015 out_ready  in  1  downstream accepts the word.
REQ-016 out_data  out  32  four int8 results, first result in [7:0].
REQ-017 out_lanes  out  3  number of valid bytes in out_data (1..4).

Function
REQ-018 Config write fires when cfg_valid && cfg_ready; cfg_ready is high only while S1..S3 are all empty and no flush is pending.
REQ-019 When a config write and acc_valid coincide with cfg_ready high, the config write wins and acc_ready is 0 that cycle.
REQ-020 Pipeline enable: en = !out_valid || out_ready; all stages and the packer advance only when en is high.
REQ-021 acc_ready = en && !cfg_fire && !flush_pending.
REQ-022 S1: sum = acc_data + bias, computed 33-bit signed, saturated to the signed 32-bit range.
REQ-023 S2: q = (sum * mult + 2^30) >>> 31, using a 64-bit signed product, saturated to the signed 32-bit range.
REQ-024 S3 rounding shift: r = shift==0 ? q : (q + 2^(shift-1)) >>> shift, which rounds half toward +inf.
REQ-025 S3 output: y = clamp(r + sign-extended out_zp, ACT_MIN, ACT_MAX), truncated to 8 bits.
REQ-026 Latency: an accumulator accepted in cycle C has S1 valid in C+1, S2 in C+2, S3 in C+3, and its byte is written to the packer at the end of C+3 when there is no stall.
REQ-027 Packer: lane counter 0..3; the byte is written to lane cnt and unwritten lanes read 0.
REQ-028 On a write to lane 3: out_valid=1, out_lanes=4 in the next cycle, and cnt returns to 0.
REQ-029 out_valid is cleared on out_valid && out_ready unless a new word loads in the same cycle, in which case it stays 1 with the new data.
REQ-030 out_data and out_lanes hold stable while out_valid && !out_ready.
REQ-031 A flush pulse sets flush_pending; back-to-back flushes are idempotent.
REQ-032 When S1..S3 are empty and en is high: if cnt>0, emit the partial word with out_lanes=cnt and set cnt=0; if cnt==0, emit nothing. In both cases clear flush_pending.
REQ-033 A config change mid-word is allowed and applies only to accumulators accepted after the write.

Reset
REQ-034 While reset_n is low: out_valid=0, out_data=0, out_lanes=0, acc_ready=0, cfg_ready=0.
REQ-035 While reset_n is low: all stage valids=0, cnt=0, flush_pending=0.
REQ-036 Config reset values: bias=0, mult=0x7FFFFFFF, shift=0, out_zp=0.
REQ-037 Reset asserted mid-operation discards in-flight data and any partial word, with no output.
REQ-038 The first acc_ready=1 occurs in the first cycle after reset_n deasserts.

Verification
REQ-039 Defaults, out_ready=1, acc_data 1,2,3,4 accepted in cycles C..C+3 -> out_valid in C+7, out_data=0x04030201, out_lanes=4.
REQ-040 bias=24, mult=0x40000000, shift=2, out_zp=-5 (0xFB), acc=1000 then flush -> out_data=0x0000007B, out_lanes=1.
REQ-041 Defaults, acc 0x7FFFFFFF, -1000, 0x80000000, 0 -> out_data=0x0080807F (saturation and clamp).
REQ-042 out_ready=0 while 8 accumulators are offered -> first word held stable, acc_ready drops, no data lost; out_ready=1 -> both words emitted in order.
REQ-043 cfg_valid and acc_valid asserted together while idle -> config written, acc_ready=0 that cycle, acc accepted next cycle using the new config.
REQ-044 reset_n pulsed low with 3 results in the packer and 2 in flight, then 4 new accs accepted -> only the word from the new accs is emitted, with config back at reset values.

Source files
------------

// File: rtl/cfu_requant_if.sv
// Handshake bundle for the requantizer: config writes, accumulator input,
// flush request and the packed int8 output word.
interface cfu_requant_if;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic        acc_valid;
  logic        acc_ready;
  logic [31:0] acc_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_lanes;

  modport master (
    output cfg_valid, cfg_addr, cfg_data, acc_valid, acc_data, flush, out_ready,
    input  cfg_ready, acc_ready, out_valid, out_data, out_lanes
  );

  modport slave (
    input  cfg_valid, cfg_addr, cfg_data, acc_valid, acc_data, flush, out_ready,
    output cfg_ready, acc_ready, out_valid, out_data, out_lanes
  );
endinterface

// File: rtl/cfu_requant.sv
// Requantizes 32-bit accumulators to int8 (bias, Q31 multiply, rounding shift,
// zero point, clamp) in a 3-stage pipeline and packs four results per word.
module cfu_requant #(
  parameter int ACT_MIN = -128,
  parameter int ACT_MAX = 127
) (
  input logic          clk,
  input logic          reset_n,
  cfu_requant_if.slave bus
);

  localparam logic signed [63:0] ACT_MIN_W = 64'(ACT_MIN);
  localparam logic signed [63:0] ACT_MAX_W = 64'(ACT_MAX);
  localparam logic signed [63:0] S32_MAX   = 64'sh0000_0000_7FFF_FFFF;
  localparam logic signed [63:0] S32_MIN   = 64'shFFFF_FFFF_8000_0000;
  localparam logic signed [63:0] HALF_Q31  = 64'sh0000_0000_4000_0000;

  function automatic logic signed [63:0] sx64(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [31:0] sat32(input logic signed [63:0] v);
    logic [31:0] r;
    if (v > S32_MAX) begin
      r = 32'h7FFF_FFFF;
    end else if (v < S32_MIN) begin
      r = 32'h8000_0000;
    end else begin
      r = v[31:0];
    end
    return r;
  endfunction

  function automatic logic [7:0] clamp_act(input logic signed [63:0] v);
    logic signed [63:0] c;
    if (v > ACT_MAX_W) begin
      c = ACT_MAX_W;
    end else if (v < ACT_MIN_W) begin
      c = ACT_MIN_W;
    end else begin
      c = v;
    end
    return c[7:0];
  endfunction

  logic [31:0] bias_q, bias_d, mult_q, mult_d;
  logic [4:0]  shift_q, shift_d;
  logic [7:0]  zp_q, zp_d;
  logic        s1_v_q, s1_v_d, s2_v_q, s2_v_d, s3_v_q, s3_v_d;
  logic [31:0] s1_q, s1_d, s2_q, s2_d;
  logic [7:0]  s3_q, s3_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] buf_q, buf_d;
  logic        flush_pending_q, flush_pending_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic [2:0]  out_lanes_q, out_lanes_d;

  logic en, stages_empty, cfg_ready, cfg_fire, acc_ready, acc_fire, flush_go;
  logic signed [63:0] sum_w, prod_w, q_w, rnd_w, y_w;

  // Handshakes; both readies are forced low while reset is held.
  always_comb begin
    en           = !out_valid_q || bus.out_ready;
    stages_empty = !s1_v_q && !s2_v_q && !s3_v_q;
    cfg_ready    = reset_n && stages_empty && !flush_pending_q;
    cfg_fire     = bus.cfg_valid && cfg_ready;
    acc_ready    = reset_n && en && !cfg_fire && !flush_pending_q;
    acc_fire     = bus.acc_valid && acc_ready;
    flush_go     = flush_pending_q && stages_empty && en;
  end

  assign bus.cfg_ready = cfg_ready;
  assign bus.acc_ready = acc_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_lanes = out_lanes_q;

  // Config register writes.
  always_comb begin
    bias_d  = bias_q;
    mult_d  = mult_q;
    shift_d = shift_q;
    zp_d    = zp_q;
    if (cfg_fire) begin
      case (bus.cfg_addr)
        2'd0:    bias_d  = bus.cfg_data;
        2'd1:    mult_d  = bus.cfg_data;
        2'd2:    shift_d = bus.cfg_data[4:0];
        2'd3:    zp_d    = bus.cfg_data[7:0];
        default: bias_d  = bias_q;
      endcase
    end else begin
      bias_d = bias_q;
    end
  end

  // Datapath arithmetic, all in 64-bit signed so no intermediate can wrap.
  always_comb begin
    sum_w  = sx64(bus.acc_data) + sx64(bias_q);
    prod_w = sx64(s1_q) * sx64(mult_q);
    q_w    = (prod_w + HALF_Q31) >>> 6'd31;
    if (shift_q == 5'd0) begin
      rnd_w = sx64(s2_q);
    end else begin
      rnd_w = (sx64(s2_q) + (64'sd1 <<< (shift_q - 5'd1))) >>> shift_q;
    end
    y_w = rnd_w + sx64({{24{zp_q[7]}}, zp_q});
  end

  // Stage registers advance together under the output-side enable.
  always_comb begin
    s1_v_d = s1_v_q;
    s2_v_d = s2_v_q;
    s3_v_d = s3_v_q;
    s1_d   = s1_q;
    s2_d   = s2_q;
    s3_d   = s3_q;
    if (en) begin
      s1_v_d = acc_fire;
      s2_v_d = s1_v_q;
      s3_v_d = s2_v_q;
      s1_d   = sat32(sum_w);
      s2_d   = sat32(q_w);
      s3_d   = clamp_act(y_w);
    end else begin
      s1_v_d = s1_v_q;
    end
  end

  // Packer, flush handling and output word register.
  always_comb begin
    cnt_d           = cnt_q;
    buf_d           = buf_q;
    flush_pending_d = flush_pending_q || bus.flush;
    out_data_d      = out_data_q;
    out_lanes_d     = out_lanes_q;
    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (en && s3_v_q) begin
      case (cnt_q)
        2'd0: begin buf_d[7:0]   = s3_q; cnt_d = 2'd1; end
        2'd1: begin buf_d[15:8]  = s3_q; cnt_d = 2'd2; end
        2'd2: begin buf_d[23:16] = s3_q; cnt_d = 2'd3; end
        2'd3: begin
          out_valid_d = 1'b1;
          out_data_d  = {s3_q, buf_q};
          out_lanes_d = 3'd4;
          cnt_d       = 2'd0;
          buf_d       = 24'd0;
        end
        default: cnt_d = cnt_q;
      endcase
    end else if (flush_go) begin
      flush_pending_d = bus.flush;
      if (cnt_q != 2'd0) begin
        out_valid_d = 1'b1;
        out_data_d  = {8'h00, buf_q};
        out_lanes_d = {1'b0, cnt_q};
        cnt_d       = 2'd0;
        buf_d       = 24'd0;
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bias_q          <= 32'd0;
      mult_q          <= 32'h7FFF_FFFF;
      shift_q         <= 5'd0;
      zp_q            <= 8'd0;
      s1_v_q          <= 1'b0;
      s2_v_q          <= 1'b0;
      s3_v_q          <= 1'b0;
      s1_q            <= 32'd0;
      s2_q            <= 32'd0;
      s3_q            <= 8'd0;
      cnt_q           <= 2'd0;
      buf_q           <= 24'd0;
      flush_pending_q <= 1'b0;
      out_valid_q     <= 1'b0;
      out_data_q      <= 32'd0;
      out_lanes_q     <= 3'd0;
    end else begin
      bias_q          <= bias_d;
      mult_q          <= mult_d;
      shift_q         <= shift_d;
      zp_q            <= zp_d;
      s1_v_q          <= s1_v_d;
      s2_v_q          <= s2_v_d;
      s3_v_q          <= s3_v_d;
      s1_q            <= s1_d;
      s2_q            <= s2_d;
      s3_q            <= s3_d;
      cnt_q           <= cnt_d;
      buf_q           <= buf_d;
      flush_pending_q <= flush_pending_d;
      out_valid_q     <= out_valid_d;
      out_data_q      <= out_data_d;
      out_lanes_q     <= out_lanes_d;
    end
  end

endmodule

// File: tb/tb_cfu_requant.sv
// Directed bench for cfu_requant: an arithmetic reference model plus scoreboard
// checked every cycle, and literal expectations for the key vectors.
module tb_cfu_requant;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  cfu_requant_if bus();

  cfu_requant dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; logic [2:0] lanes; } word_t;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  longint m_bias, m_mult, m_shift, m_zp;
  logic [7:0] m_bytes[$];
  word_t exp_q[$];
  logic [31:0] last_word = 32'd0;
  logic [2:0]  last_lanes = 3'd0;
  int first_valid_cyc = 0;
  logic prev_valid = 1'b0;
  logic hold_pending = 1'b0;
  logic [31:0] held_data = 32'd0;
  logic [2:0]  held_lanes = 3'd0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic longint floordiv(input longint a, input longint b);
    longint q = a / b;
    if ((a % b) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  function automatic longint clampl(input longint v, input longint lo, input longint hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  // Reference requantization straight from the arithmetic definition.
  function automatic logic [7:0] ref_byte(input longint acc, input longint bias, input longint mult,
                                          input longint sh, input longint zp);
    longint p31 = 64'sd1 <<< 31;
    longint lo = -p31;
    longint hi = p31 - 1;
    longint s, q, r, y;
    s = clampl(acc + bias, lo, hi);
    q = clampl(floordiv(s * mult + (p31 / 2), p31), lo, hi);
    if (sh == 0) r = q;
    else r = floordiv(q + (64'sd1 <<< (sh - 1)), 64'sd1 <<< sh);
    y = clampl(r + zp, -128, 127);
    return y[7:0];
  endfunction

  task automatic pack_word();
    word_t w;
    w.data = 32'd0;
    for (int i = 0; i < m_bytes.size(); i++) w.data[8*i +: 8] = m_bytes[i];
    w.lanes = 3'(m_bytes.size());
    exp_q.push_back(w);
    m_bytes.delete();
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Observe all handshakes half a cycle before the edge they complete on.
  always @(negedge clk) begin
    if (!reset_n) begin
      m_bias = 0; m_mult = 64'sh7FFF_FFFF; m_shift = 0; m_zp = 0;
      m_bytes.delete();
      exp_q.delete();
      hold_pending = 1'b0;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_out_lanes", bus.out_lanes, 0);
      check("rst_acc_ready", bus.acc_ready, 0);
      check("rst_cfg_ready", bus.cfg_ready, 0);
    end else begin
      if (bus.out_valid) begin
        if (!prev_valid) first_valid_cyc = cyc;
        if (hold_pending) begin
          check("hold_data", bus.out_data, held_data);
          check("hold_lanes", bus.out_lanes, held_lanes);
        end
        if (exp_q.size() == 0) begin
          check("spurious_word", bus.out_valid, 0);
        end else if (bus.out_ready) begin
          check("word_data", bus.out_data, exp_q[0].data);
          check("word_lanes", bus.out_lanes, exp_q[0].lanes);
          last_word = bus.out_data;
          last_lanes = bus.out_lanes;
          void'(exp_q.pop_front());
        end
        hold_pending = !bus.out_ready;
        held_data = bus.out_data;
        held_lanes = bus.out_lanes;
      end else begin
        hold_pending = 1'b0;
      end
      if (bus.cfg_valid && bus.cfg_ready) begin
        case (bus.cfg_addr)
          2'd0: m_bias = longint'($signed(bus.cfg_data));
          2'd1: m_mult = longint'($signed(bus.cfg_data));
          2'd2: m_shift = longint'(bus.cfg_data[4:0]);
          2'd3: m_zp = longint'($signed(bus.cfg_data[7:0]));
          default: m_bias = m_bias;
        endcase
      end
      if (bus.acc_valid && bus.acc_ready) begin
        m_bytes.push_back(ref_byte(longint'($signed(bus.acc_data)), m_bias, m_mult, m_shift, m_zp));
        if (m_bytes.size() == 4) pack_word();
      end
      if (bus.flush && m_bytes.size() > 0) pack_word();
    end
    prev_valid = reset_n && bus.out_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_acc(input logic [31:0] d, output int acc_cyc);
    bit got = 1'b0;
    acc_cyc = -1;
    bus.acc_valid = 1'b1;
    bus.acc_data = d;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (bus.acc_ready) begin got = 1'b1; acc_cyc = cyc; end
      tick();
    end
    bus.acc_valid = 1'b0;
    check("acc_accepted", got, 1);
  endtask

  task automatic write_cfg(input logic [1:0] a, input logic [31:0] d);
    bit got = 1'b0;
    bus.cfg_valid = 1'b1;
    bus.cfg_addr = a;
    bus.cfg_data = d;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      got = bus.cfg_ready;
      tick();
    end
    bus.cfg_valid = 1'b0;
    check("cfg_accepted", got, 1);
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && k < 300) begin
      tick();
      k++;
    end
    check("drain_done", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
    $fatal(1);
  end

  initial begin
    int c0, c;
    bus.cfg_valid = 1'b0; bus.cfg_addr = 2'd0; bus.cfg_data = 32'd0;
    bus.acc_valid = 1'b0; bus.acc_data = 32'd0; bus.flush = 1'b0; bus.out_ready = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("first_acc_ready", bus.acc_ready, 1);
    tick();

    check("pin_req040", ref_byte(1000, 24, 64'sh4000_0000, 2, -5), 8'h7B);
    check("pin_sat_hi", ref_byte(64'sh7FFF_FFFF, 0, 64'sh7FFF_FFFF, 0, 0), 8'h7F);
    check("pin_sat_lo", ref_byte(-64'sd2147483648, 0, 64'sh7FFF_FFFF, 0, 0), 8'h80);
    check("pin_half_up", ref_byte(6, 0, 64'sh7FFF_FFFF, 2, 0), 8'h02);
    check("pin_half_neg", ref_byte(-6, 0, 64'sh7FFF_FFFF, 2, 0), 8'hFF);
    check("pin_neg_mult", ref_byte(100, 0, -64'sd2147483648, 0, 0), 8'h9C);

    // Defaults: identity path and pipeline latency.
    send_acc(32'd1, c0); send_acc(32'd2, c); send_acc(32'd3, c); send_acc(32'd4, c);
    drain();
    check("latency", first_valid_cyc - c0, 7);
    check("t1_word", last_word, 32'h0403_0201);
    check("t1_lanes", last_lanes, 4);

    // Saturation and clamp.
    send_acc(32'h7FFF_FFFF, c); send_acc(-32'sd1000, c); send_acc(32'h8000_0000, c); send_acc(32'd0, c);
    drain();
    check("t2_word", last_word, 32'h0080_807F);

    // Full config path with a partial word and repeated flushes.
    write_cfg(2'd0, 32'd24); write_cfg(2'd1, 32'h4000_0000);
    write_cfg(2'd2, 32'd2);  write_cfg(2'd3, 32'h0000_00FB);
    send_acc(32'd1000, c);
    do_flush(); do_flush();
    drain();
    check("t3_word", last_word, 32'h0000_007B);
    check("t3_lanes", last_lanes, 1);
    do_flush();
    repeat (5) tick();
    write_cfg(2'd0, 32'd0); write_cfg(2'd1, 32'h7FFF_FFFF);
    write_cfg(2'd2, 32'd0); write_cfg(2'd3, 32'd0);

    // Downstream stall with 8 accumulators offered.
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 5; i <= 12; i++) send_acc(32'(i), c);
      end
      begin
        repeat (20) tick();
        check("stall_acc_ready", bus.acc_ready, 0);
        check("stall_out_valid", bus.out_valid, 1);
        check("stall_word", bus.out_data, 32'h0807_0605);
        bus.out_ready = 1'b1;
      end
    join
    drain();
    check("t4_word2", last_word, 32'h0C0B_0A09);

    // Config and accumulator offered together; then a mid-word config change.
    bus.cfg_valid = 1'b1; bus.cfg_addr = 2'd0; bus.cfg_data = 32'd10;
    bus.acc_valid = 1'b1; bus.acc_data = 32'd1;
    @(negedge clk);
    check("both_cfg_ready", bus.cfg_ready, 1);
    check("both_acc_ready", bus.acc_ready, 0);
    tick();
    bus.cfg_valid = 1'b0;
    @(negedge clk);
    check("acc_after_cfg", bus.acc_ready, 1);
    tick();
    bus.acc_valid = 1'b0;
    send_acc(32'd2, c);
    write_cfg(2'd0, 32'd0);
    send_acc(32'd3, c); send_acc(32'd4, c);
    drain();
    check("t5_word", last_word, 32'h0403_0C0B);

    // Reset mid-operation discards everything and restores config.
    write_cfg(2'd2, 32'd1);
    for (int i = 1; i <= 5; i++) send_acc(32'(i * 10), c);
    tick();
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    @(negedge clk);
    check("acc_ready_post_rst", bus.acc_ready, 1);
    tick();
    send_acc(32'd1, c); send_acc(32'd2, c); send_acc(32'd3, c); send_acc(32'd4, c);
    drain();
    check("t6_word", last_word, 32'h0403_0201);
    repeat (10) tick();
    check("no_leftover", exp_q.size() + m_bytes.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
